// File: rtl/load_misalign_sequencer.sv
// Load sequencer: issues one or two aligned word reads per load, then merges, shifts and extends the result.
// Define KIANV_LOAD_SPLIT_EN to split word-crossing loads; otherwise they return a misaligned fault.
module load_misalign_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_load_op,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_fault,
    output logic                  busy,
    output logic [1:0]            o_dbg_state
);

    // LoadOp_t uses the RISC-V funct3 encoding.
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD0  = 2'd1;
`ifdef KIANV_LOAD_SPLIT_EN
    localparam logic [1:0] ST_RD1  = 2'd2;
`endif
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [2:0]            r_op;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_fault;
`ifdef KIANV_LOAD_SPLIT_EN
    logic                  r_cross;
    logic [DATA_WIDTH-1:0] r_w0;
`endif
    logic                  w_cross;

    // Both handshakes are valid/ready: a transfer happens on a rising edge where both are high.
    assign w_cross = (((req_load_op == OP_LH) || (req_load_op == OP_LHU)) && (req_addr[1:0] == 2'd3))
                   || ((req_load_op == OP_LW) && (req_addr[1:0] != 2'd0));

    function automatic logic [31:0] f_extract(input logic [31:0] w1, input logic [31:0] w0,
                                              input logic [1:0] off, input logic [2:0] op);
        logic [31:0] v_low;
        v_low = 32'({w1, w0} >> {off, 3'b000});
        case (op)
            OP_LB:   return {{24{v_low[7]}}, v_low[7:0]};
            OP_LH:   return {{16{v_low[15]}}, v_low[15:0]};
            OP_LW:   return v_low;
            OP_LBU:  return {24'd0, v_low[7:0]};
            OP_LHU:  return {16'd0, v_low[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mem_addr   <= '0;
            r_op         <= '0;
            r_off        <= '0;
            r_resp_data  <= '0;
            r_resp_fault <= 1'b0;
`ifdef KIANV_LOAD_SPLIT_EN
            r_cross      <= 1'b0;
            r_w0         <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op       <= req_load_op;
                        r_off      <= req_addr[1:0];
                        r_mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef KIANV_LOAD_SPLIT_EN
                        r_cross    <= w_cross;
                        r_state    <= ST_RD0;
`else
                        if (w_cross) begin
                            r_resp_data  <= '0;
                            r_resp_fault <= 1'b1;
                            r_state      <= ST_RESP;
                        end else begin
                            r_state <= ST_RD0;
                        end
`endif
                    end
                end
                ST_RD0: begin
                    if (mem_ready) begin
`ifdef KIANV_LOAD_SPLIT_EN
                        if (r_cross) begin
                            r_w0       <= mem_rdata;
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
                            r_state    <= ST_RD1;
                        end else begin
                            r_resp_data  <= f_extract(32'd0, mem_rdata, r_off, r_op);
                            r_resp_fault <= 1'b0;
                            r_state      <= ST_RESP;
                        end
`else
                        r_resp_data  <= f_extract(32'd0, mem_rdata, r_off, r_op);
                        r_resp_fault <= 1'b0;
                        r_state      <= ST_RESP;
`endif
                    end
                end
`ifdef KIANV_LOAD_SPLIT_EN
                ST_RD1: begin
                    if (mem_ready) begin
                        r_resp_data  <= f_extract(mem_rdata, r_w0, r_off, r_op);
                        r_resp_fault <= 1'b0;
                        r_state      <= ST_RESP;
                    end
                end
`endif
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef KIANV_LOAD_SPLIT_EN
    assign mem_valid = (r_state == ST_RD0) || (r_state == ST_RD1);
`else
    assign mem_valid = (r_state == ST_RD0);
`endif
    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = (r_state == ST_RESP);
    assign busy        = (r_state != ST_IDLE);
    assign mem_addr    = r_mem_addr;
    assign resp_data   = r_resp_data;
    assign resp_fault  = r_resp_fault;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_misalign_sequencer.sv
// Bench for load_misalign_sequencer: directed loads plus random loads against a byte-level memory model.
module tb_load_misalign_sequencer;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        reset, req_valid, mem_ready;
  logic [31:0] req_addr, mem_rdata;
  logic [2:0]  req_load_op;
  logic        req_ready, mem_valid, resp_valid, resp_fault, busy;
  logic [31:0] mem_addr, resp_data;
  logic [1:0]  dbg_state;

  load_misalign_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_load_op(req_load_op), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem_b[logic [31:0]];
  logic [31:0] last_data;
  logic        last_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem_b.exists(a)) mem_b[a] = 8'($urandom);
    return mem_b[a];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Reference: gather the load's bytes from byte memory, extend, and list the word reads expected.
  task automatic model(input logic [31:0] addr, input logic [2:0] op, input int waits,
                       output logic [31:0] data, output logic fault, output int lat);
    int size;
    logic [31:0] val;
    logic [31:0] base;
    case (op)
      LB, LBU: size = 1;
      LH, LHU: size = 2;
      LW:      size = 4;
      default: size = 0;
    endcase
    val = 32'd0;
    for (int i = 0; i < size; i++) val = val | (32'(rd_byte(addr + 32'(i))) << (8 * i));
    if (op == LB && val[7])  val = val | 32'hFFFF_FF00;
    if (op == LH && val[15]) val = val | 32'hFFFF_0000;
    base = addr & 32'hFFFF_FFFC;
    exp_q.delete();
    fault = 1'b0;
    data = val;
    if (size != 0 && (int'(addr[1:0]) + size > 4)) begin
`ifdef KIANV_LOAD_SPLIT_EN
      exp_q.push_back(base);
      exp_q.push_back(base + 32'd4);
      lat = 3 + 2 * waits;
`else
      fault = 1'b1;
      data = 32'd0;
      lat = 1;
`endif
    end else begin
      exp_q.push_back(base);
      lat = 2 + waits;
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input int waits,
                         output logic [31:0] got);
    logic [31:0] e_data;
    logic        e_fault;
    int          e_lat, n, wcnt;
    bit          done;
    model(addr, op, waits, e_data, e_fault, e_lat);
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("resp_one_cycle", resp_valid, 0);
    check("resp_data_hold", resp_data, last_data);
    req_valid = 1'b1; req_addr = addr; req_load_op = op; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_load_op = 3'($urandom);
    n = 1; wcnt = 0; done = 0; got = 32'd0;
    while (!done && n <= 40) begin
      if (resp_valid) begin
        done = 1;
        check("latency", n, e_lat);
        check("resp_data", resp_data, e_data);
        check("resp_fault", resp_fault, e_fault);
        check("reads_left", exp_q.size(), 0);
        check("mem_valid_in_resp", mem_valid, 0);
        check("busy_in_resp", busy, 1);
        got = resp_data;
        last_data = resp_data;
        last_fault = resp_fault;
      end else begin
        mem_ready = 1'b0;
        if (mem_valid) begin
          if (exp_q.size() == 0) check("unexpected_read", mem_valid, 0);
          else begin
            check("mem_addr", mem_addr, exp_q[0]);
            if (wcnt == waits) begin
              mem_ready = 1'b1;
              mem_rdata = word_at({mem_addr[31:2], 2'b00});
              void'(exp_q.pop_front());
              wcnt = 0;
            end else begin
              mem_rdata = $urandom;
              wcnt++;
            end
          end
        end
        @(negedge clk);
        n++;
      end
    end
    if (!done) check("resp_timeout", resp_valid, 1);
    mem_ready = 1'b0;
  endtask

  // Start a load, then assert reset while read abort_idx is stalled (with mem_ready also high).
  task automatic do_abort(input logic [31:0] addr, input logic [2:0] op, input int waits, input int abort_idx);
    logic [31:0] e_data;
    logic        e_fault;
    int          e_lat, n, wcnt, reads;
    bit          fired;
    model(addr, op, waits, e_data, e_fault, e_lat);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_load_op = op; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; wcnt = 0; reads = 0; fired = 0;
    while (!fired && n <= 40) begin
      mem_ready = 1'b0;
      if (reads == abort_idx && wcnt == 1) begin
        fired = 1;
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = $urandom;
      end else if (mem_valid) begin
        if (wcnt == waits) begin
          mem_ready = 1'b1;
          mem_rdata = word_at({mem_addr[31:2], 2'b00});
          wcnt = 0; reads++;
        end else wcnt++;
      end
      @(negedge clk);
      n++;
    end
    check("abort_reached", fired, 1);
    check("abort_mem_valid", mem_valid, 0);
    check("abort_state", dbg_state, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 1);
    reset = 1'b0; mem_ready = 1'b0;
    last_data = 32'd0;
    @(negedge clk);
    check("post_abort_resp", resp_valid, 0);
    check("post_abort_mem_valid", mem_valid, 0);
  endtask

  logic [31:0] got;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_load_op = LW;
    mem_ready = 1'b0; mem_rdata = 32'd0; last_data = 32'd0; last_fault = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_fault", resp_fault, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;

    set_word(32'h100, 32'hDEAD_BEEF);
    do_load(32'h100, LW, 0, got);
    check("lw_100", got, 32'hDEAD_BEEF);
    do_load(32'h100, LW, 2, got);
    check("lw_100_wait", got, 32'hDEAD_BEEF);
    set_word(32'h100, 32'h80FF_FFFF);
    do_load(32'h103, LB, 0, got);
    check("lb_103", got, 32'hFFFF_FF80);
    do_load(32'h103, LBU, 1, got);
    check("lbu_103", got, 32'h0000_0080);

    set_word(32'h200, 32'h1234_5678);
    set_word(32'h204, 32'hAABB_CCDD);
    set_word(32'hFFFF_FFFC, 32'h1122_3344);
    set_word(32'h0, 32'h5566_7788);
`ifdef KIANV_LOAD_SPLIT_EN
    do_load(32'h203, LH, 0, got);
    check("lh_203", got, 32'hFFFF_DD12);
    do_load(32'hFFFF_FFFE, LW, 0, got);
    check("lw_wrap", got, 32'h7788_1122);
    do_abort(32'h101, LW, 3, 1);
`else
    do_load(32'h3, LHU, 0, got);
    check("lhu_3_data", got, 32'h0);
    check("lhu_3_fault", last_fault, 1);
    do_abort(32'h100, LW, 3, 0);
`endif
    set_word(32'h100, 32'hCAFE_F00D);
    do_load(32'h100, LW, 0, got);
    check("lw_after_abort", got, 32'hCAFE_F00D);

    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      logic [2:0]  op;
      int          w;
      case ($urandom_range(0, 2))
        0:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        1:       a = 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: op = LB; 1: op = LH; 2: op = LW; 3: op = LBU; default: op = LHU;
        endcase
      end else begin
        case ($urandom_range(0, 2))
          0: op = 3'b011; 1: op = 3'b110; default: op = 3'b111;
        endcase
      end
      w = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      do_load(a, op, w, got);
    end

    @(negedge clk);
    check("final_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_misalign_sequencer.md
Name: load_misalign_sequencer

Overview:
- Memory-side controller in front of the load-alignment datapath of the 5-stage KianV core.
- Accepts one load request (byte address plus LoadOp_t) and issues one or two aligned word reads on the data bus.
- Merges the returned words, byte-shifts them, then sign- or zero-extends per LoadOp.
- Returns a single word-aligned result, so the writeback path sees any load, including word-crossing ones, as one completed access.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses; the word-increment wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, data bus width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  load request present.
- req_ready  output  1  sequencer can accept a request.
- req_addr  input  ADDR_WIDTH  byte address of the load (ALU result).
- req_load_op  input  LoadOp_t  load type: LOAD_OP_LB, LOAD_OP_LH, LOAD_OP_LW, LOAD_OP_LBU or LOAD_OP_LHU.
- mem_valid  output  1  word read request to the data bus.
- mem_ready  input  1  bus completion; mem_rdata is valid in this cycle.
- mem_addr  output  ADDR_WIDTH  word-aligned read address (bits [1:0] always 0).
- mem_rdata  input  DATA_WIDTH  read data.
- resp_valid  output  1  one-cycle pulse; result available.
- resp_data  output  DATA_WIDTH  aligned, extended load result.
- resp_fault  output  1  qualifies resp_valid; the access was not performed.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, req_ready=1, mem_valid=0, mem_addr=0, resp_valid=0, resp_data=0, resp_fault=0, busy=0.
- A reset asserted mid-operation aborts the access. mem_valid drops the cycle after reset is sampled, and the in-flight mem_ready is ignored.
- States: IDLE, RD0, RD1, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, op and off=addr[1:0].
  - Compute cross = (op is LH/LHU and off==3) or (op is LW and off!=0). Byte loads never cross.
  - Go to RD0 with mem_addr={addr[A-1:2],2'b00}.
- RD0: mem_valid=1. mem_addr is held stable until mem_ready.
  - On mem_ready, capture w0=mem_rdata.
  - If cross: go to RD1 with mem_addr+=4, wrapping 0xFFFFFFFC -> 0x00000000.
  - Otherwise go to RESP.
- RD1: mem_valid=1. On mem_ready, capture w1 and go to RESP.
- mem_valid deasserts in the cycle after the mem_ready of the last read. No bubble cycle is inserted between RD0 and RD1; mem_valid stays high across that transition.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE. req_ready is low in RESP, so back-to-back requests are spaced by at least one cycle.
  - Merge: form 64-bit {w1,w0}, with w1=0 when not crossing, and shift right by off*8.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW takes the low 32 bits.
  - Any other LoadOp_t encoding: single read, resp_data=0, resp_fault=0.
- resp_data and resp_fault are registered. They hold their values until the next RESP.
- Latency from the accept cycle T, with zero-wait memory:
  - Non-crossing: mem_valid at T+1, resp_valid at T+2.
  - Crossing: reads at T+1 and T+2, resp_valid at T+3.
  - Each memory wait cycle adds one cycle.
- req_valid is ignored while busy=1. The requester must hold its request until req_ready&&req_valid.

Optional Feature:
- Macro: KIANV_LOAD_SPLIT_EN.
- Defined: crossing loads are split into two word reads as described above.
- Not defined: RD1 is not implemented. A crossing request is accepted but issues no memory read (mem_valid stays 0). The sequencer goes IDLE->RESP and pulses resp_valid=1 with resp_fault=1 and resp_data=0 one cycle after accept, so the pipeline can raise a load-address-misaligned trap.
- Non-crossing behaviour is identical in both builds.

Test Plan:
- LW addr 0x100, mem returns 0xDEADBEEF with 0 wait -> mem_addr=0x100, one read, resp_valid at T+2, resp_data=0xDEADBEEF, resp_fault=0.
- LB addr 0x103, word 0x80FFFFFF -> resp_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH addr 0x0203 (split build), words 0x12345678 at 0x200 and 0xAABBCCDD at 0x204 -> reads 0x200 then 0x204, resp_data=0xFFFFDD12, resp_valid at T+3.
- LW addr 0xFFFFFFFE (split build), words 0x11223344 and 0x55667788 -> second mem_addr=0x00000000, resp_data=0x77881122.
- LW addr 0x101 with 3 mem wait cycles on each read, reset pulsed during the second read -> mem_valid=0 the next cycle, state IDLE, no resp_valid. A fresh LW 0x100 afterwards completes normally.
- Without KIANV_LOAD_SPLIT_EN: LHU addr 0x3 -> no mem_valid, resp_valid with resp_fault=1, resp_data=0 one cycle after accept.
